// File: rtl/aes_port_pkg.sv
// -----------------------------------------------------------------------------
// aes_port_pkg
//   Shared definitions for the AES port sequencer: block width, FSM state
//   encoding and a small helper to classify idle states.
// -----------------------------------------------------------------------------
package aes_port_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE_KEY  = 3'd0,
    ST_IDLE_DATA = 3'd1,
    ST_START     = 3'd2,
    ST_RUN       = 3'd3,
    ST_SEND      = 3'd4,
    ST_GUARD     = 3'd5,
    ST_DRAIN     = 3'd6
  } ctrl_state_e;

  function automatic logic is_idle(input ctrl_state_e s);
    return (s == ST_IDLE_KEY) || (s == ST_IDLE_DATA);
  endfunction

endpackage

// File: rtl/aes_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// aes_ctrl_wdog
//   Watchdog counter for the RUN phase of the AES sequencer.
//   Ports:
//     clk, rst_n : clock / async active-low reset
//     clr        : synchronous clear to zero (has priority over en)
//     en         : count one cycle
//     expire     : counter has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module aes_ctrl_wdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  // Saturates at LAST so a stalled enable can never wrap back to a
  // non-expired value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/aes_port_ctrl.sv
// -----------------------------------------------------------------------------
// aes_port_ctrl
//   Sequencer between the byte-serial port and the AES-128 core. First word
//   from the receiver is the key, the next is a plaintext block. Loads the key,
//   starts the core, watches for done with a watchdog and hands the result to
//   the transmitter.
//   Ports:
//     clk, rst_n               : clock / async active-low reset
//     rx_data, rx_en           : word from receiver + completion strobe
//     core_key, core_key_load  : key register and its load pulse
//     core_din, core_start     : plaintext register and start pulse
//     core_dout, core_done     : ciphertext from core and its strobe
//     tx_data, tx_start        : result register and transmit pulse
//     tx_busy                  : transmitter busy
//     clr_err                  : clear sticky error flags
//     err_overflow,err_timeout : sticky error flags
//     blk_cnt                  : completed block count (wraps)
//     busy                     : FSM outside the idle states
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE_KEY  | waiting for key word
//   ST_IDLE_DATA | key loaded, waiting for plaintext word
//   ST_START     | core_start high, watchdog cleared
//   ST_RUN       | core encrypting, watchdog counting
//   ST_SEND      | result captured, waiting to fire tx_start
//   ST_GUARD     | one cycle covering transmitter busy latency
//   ST_DRAIN     | waiting for transmitter to finish
// -----------------------------------------------------------------------------
module aes_port_ctrl
  import aes_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int KEY_REUSE      = 1,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AES_BLK_W-1:0] rx_data,
  input  logic                 rx_en,
  output logic [AES_BLK_W-1:0] core_key,
  output logic                 core_key_load,
  output logic [AES_BLK_W-1:0] core_din,
  output logic                 core_start,
  input  logic [AES_BLK_W-1:0] core_dout,
  input  logic                 core_done,
  output logic [AES_BLK_W-1:0] tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 clr_err,
  output logic                 err_overflow,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     blk_cnt,
  output logic                 busy
);

  ctrl_state_e state_q, state_d;

  logic ld_key;
  logic ld_din;
  logic ld_tx;
  logic fire;
  logic ovf_set;
  logic tmo_set;
  logic wdog_clr;
  logic wdog_en;
  logic wdog_exp;

  aes_ctrl_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wdog_clr),
    .en     (wdog_en),
    .expire (wdog_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE_KEY;
    end else begin
      state_q <= state_d;
    end
  end

  // tx_start is a flop, so the transmit decision is taken one cycle ahead:
  // in RUN when core_done arrives with an idle transmitter, or in SEND once
  // tx_busy drops. SEND leaves as soon as the pulse is on the output.
  always_comb begin
    state_d  = state_q;
    ld_key   = 1'b0;
    ld_din   = 1'b0;
    ld_tx    = 1'b0;
    fire     = 1'b0;
    tmo_set  = 1'b0;
    wdog_clr = 1'b0;
    wdog_en  = 1'b0;
    ovf_set  = rx_en && !is_idle(state_q);

    unique case (state_q)
      ST_IDLE_KEY: begin
        if (rx_en) begin
          ld_key  = 1'b1;
          state_d = ST_IDLE_DATA;
        end
      end
      ST_IDLE_DATA: begin
        if (rx_en) begin
          ld_din  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        wdog_clr = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        wdog_en = 1'b1;
        // core_done in the expiry cycle takes priority over the timeout
        if (core_done) begin
          ld_tx   = 1'b1;
          fire    = !tx_busy;
          state_d = ST_SEND;
        end else if (wdog_exp) begin
          tmo_set = 1'b1;
          state_d = ST_IDLE_KEY;
        end
      end
      ST_SEND: begin
        if (tx_start) begin
          state_d = ST_GUARD;
        end else if (!tx_busy) begin
          fire = 1'b1;
        end
      end
      ST_GUARD: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
          state_d = (KEY_REUSE != 0) ? ST_IDLE_DATA : ST_IDLE_KEY;
        end
      end
      default: begin
        state_d = ST_IDLE_KEY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_key      <= '0;
      core_key_load <= 1'b0;
      core_din      <= '0;
      core_start    <= 1'b0;
      tx_data       <= '0;
      tx_start      <= 1'b0;
      err_overflow  <= 1'b0;
      err_timeout   <= 1'b0;
      blk_cnt       <= '0;
      busy          <= 1'b0;
    end else begin
      core_key_load <= ld_key;
      core_start    <= ld_din;
      tx_start      <= fire;
      busy          <= !is_idle(state_d);

      if (ld_key) begin
        core_key <= rx_data;
      end
      if (ld_din) begin
        core_din <= rx_data;
      end
      if (ld_tx) begin
        tx_data <= core_dout;
      end
      if (fire) begin
        blk_cnt <= blk_cnt + CNT_W'(1);
      end

      // set beats clear when both happen in the same cycle
      if (ovf_set) begin
        err_overflow <= 1'b1;
      end else if (clr_err) begin
        err_overflow <= 1'b0;
      end

      if (tmo_set) begin
        err_timeout <= 1'b1;
      end else if (clr_err) begin
        err_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_port_ctrl.sv
module tb_aes_port_ctrl;

  localparam int T  = 16;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] rx_data = '0;
  logic         rx_en = 1'b0;
  logic [127:0] core_key;
  logic         core_key_load;
  logic [127:0] core_din;
  logic         core_start;
  logic [127:0] core_dout = '0;
  logic         core_done = 1'b0;
  logic [127:0] tx_data;
  logic         tx_start;
  logic         tx_busy = 1'b0;
  logic         clr_err = 1'b0;
  logic         err_overflow;
  logic         err_timeout;
  logic [CW-1:0] blk_cnt;
  logic         busy;

  always #5 clk = ~clk;

  aes_port_ctrl #(
    .TIMEOUT_CYCLES (T),
    .KEY_REUSE      (1),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_en         (rx_en),
    .core_key      (core_key),
    .core_key_load (core_key_load),
    .core_din      (core_din),
    .core_start    (core_start),
    .core_dout     (core_dout),
    .core_done     (core_done),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .clr_err       (clr_err),
    .err_overflow  (err_overflow),
    .err_timeout   (err_timeout),
    .blk_cnt       (blk_cnt),
    .busy          (busy)
  );

  typedef struct {
    logic [127:0]  data;
    logic [CW-1:0] cnt;
  } tx_exp_t;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [127:0]  exp_key_q[$];
  logic [127:0]  exp_din_q[$];
  tx_exp_t       exp_tx_q[$];
  int            n_key_load = 0;
  int            n_start = 0;
  logic [CW-1:0] exp_blk = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    tx_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (core_key_load) begin
          n_key_load++;
          if (exp_key_q.size() == 0) fail_now("spurious core_key_load");
          else chk("core_key", core_key, exp_key_q.pop_front());
        end
        if (core_start) begin
          n_start++;
          if (exp_din_q.size() == 0) fail_now("spurious core_start");
          else chk("core_din", core_din, exp_din_q.pop_front());
        end
        if (tx_start) begin
          if (exp_tx_q.size() == 0) fail_now("spurious tx_start");
          else begin
            e = exp_tx_q.pop_front();
            chk("tx_data", tx_data, e.data);
            chk("blk_cnt at tx_start", 128'(blk_cnt), 128'(e.cnt));
          end
        end
      end
    end
  endtask

  task automatic send_word(input logic [127:0] d);
    rx_data = d;
    rx_en   = 1'b1;
    tick();
    rx_en   = 1'b0;
  endtask

  task automatic send_key(input logic [127:0] k);
    exp_key_q.push_back(k);
    send_word(k);
    @(negedge clk);
    chk("core_key_load latency", 128'(core_key_load), 128'(1));
  endtask

  task automatic send_pt(input logic [127:0] p);
    exp_din_q.push_back(p);
    send_word(p);
    @(negedge clk);
    chk("core_start latency", 128'(core_start), 128'(1));
  endtask

  // d = cycles after the START cycle at which core_done is pulsed (1..T)
  task automatic core_finish(input logic [127:0] dout, input int d);
    tx_exp_t e;
    repeat (d) tick();
    exp_blk = exp_blk + CW'(1);
    e.data = dout;
    e.cnt  = exp_blk;
    exp_tx_q.push_back(e);
    core_dout = dout;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    if (!tx_busy) begin
      @(negedge clk);
      chk("tx_start latency", 128'(tx_start), 128'(1));
    end
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    if (busy) fail_now({"idle timeout ", name});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " core_key"}, core_key, 128'(0));
    chk({tag, " core_key_load"}, 128'(core_key_load), 128'(0));
    chk({tag, " core_din"}, core_din, 128'(0));
    chk({tag, " core_start"}, 128'(core_start), 128'(0));
    chk({tag, " tx_data"}, tx_data, 128'(0));
    chk({tag, " tx_start"}, 128'(tx_start), 128'(0));
    chk({tag, " err_overflow"}, 128'(err_overflow), 128'(0));
    chk({tag, " err_timeout"}, 128'(err_timeout), 128'(0));
    chk({tag, " blk_cnt"}, 128'(blk_cnt), 128'(0));
    chk({tag, " busy"}, 128'(busy), 128'(0));
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int bad;
    fork
      monitor();
    join_none

    // reset state
    #12;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single block
    send_key(128'h000102030405060708090a0b0c0d0e0f);
    tick();
    send_pt(128'h00112233445566778899aabbccddeeff);
    core_finish(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10);
    wait_idle("t1");

    // 2: key reuse, three more blocks, blk_cnt wraps 3 -> 0
    send_pt(128'h11111111222222223333333344444444);
    core_finish(128'ha1a1a1a1b2b2b2b2c3c3c3c3d4d4d4d4, 1);
    wait_idle("t2a");
    send_pt(128'h55555555666666667777777788888888);
    core_finish(128'h0f0e0d0c0b0a09080706050403020100, 5);
    wait_idle("t2b");
    send_pt(128'h9999999900000000aaaaaaaabbbbbbbb);
    core_finish(128'hdeadbeefcafef00d0123456789abcdef, 7);
    wait_idle("t2c");
    tick();
    chk("key loads after reuse", 128'(n_key_load), 128'(1));
    chk("starts after reuse", 128'(n_start), 128'(4));
    chk("blk_cnt wrapped", 128'(blk_cnt), 128'(0));
    chk("core_key held", core_key, 128'h000102030405060708090a0b0c0d0e0f);

    // 3: watchdog expiry, then core_done exactly in the expiry cycle
    send_pt(128'hcccccccccccccccccccccccccccccccc);
    repeat (T) tick();
    @(negedge clk);
    chk("err_timeout before expiry", 128'(err_timeout), 128'(0));
    tick();
    @(negedge clk);
    chk("err_timeout at expiry", 128'(err_timeout), 128'(1));
    chk("busy after timeout", 128'(busy), 128'(0));
    clear_errors();
    @(negedge clk);
    chk("err_timeout cleared", 128'(err_timeout), 128'(0));
    tick();
    send_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    tick();
    send_pt(128'h3243f6a8885a308d313198a2e0370734);
    core_finish(128'h3925841d02dc09fbdc118597196a0b32, T);
    @(negedge clk);
    chk("no timeout on late done", 128'(err_timeout), 128'(0));
    wait_idle("t3");

    // 4: overflow during RUN, clear, then clear and set together
    send_pt(128'h0123456789abcdef0123456789abcdef);
    tick();
    tick();
    send_word(128'hffffffffffffffffffffffffffffffff);
    @(negedge clk);
    chk("err_overflow set", 128'(err_overflow), 128'(1));
    chk("core_din unchanged", core_din, 128'h0123456789abcdef0123456789abcdef);
    tick();
    clear_errors();
    @(negedge clk);
    chk("err_overflow cleared", 128'(err_overflow), 128'(0));
    tick();
    clr_err = 1'b1;
    send_word(128'heeeeeeeeeeeeeeeeeeeeeeeeeeeeeeee);
    clr_err = 1'b0;
    @(negedge clk);
    chk("overflow set beats clear", 128'(err_overflow), 128'(1));
    core_finish(128'h55aa55aa55aa55aa55aa55aa55aa55aa, 2);
    wait_idle("t4");
    clear_errors();

    // 5: transmitter busy at SEND, then no word accepted while draining
    tx_busy = 1'b1;
    send_pt(128'h77777777777777777777777777777777);
    core_finish(128'h13579bdf2468ace013579bdf2468ace0, 4);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start) bad++;
      tick();
    end
    chk("tx_start held while busy", 128'(bad), 128'(0));
    tx_busy = 1'b0;
    tick();
    @(negedge clk);
    chk("tx_start after busy falls", 128'(tx_start), 128'(1));
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    send_word(128'h99999999999999999999999999999999);
    @(negedge clk);
    chk("overflow in DRAIN", 128'(err_overflow), 128'(1));
    chk("busy in DRAIN", 128'(busy), 128'(1));
    tick();
    tx_busy = 1'b0;
    wait_idle("t5");
    chk("key not replaced in DRAIN", core_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("key loads total", 128'(n_key_load), 128'(2));
    clear_errors();

    // 6: reset in RUN, then reset in SEND
    send_pt(128'h44444444444444444444444444444444);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst in RUN");
    exp_din_q.delete();
    exp_tx_q.delete();
    exp_blk = '0;
    n_key_load = 0;
    n_start = 0;
    tick();
    rst_n = 1'b1;
    tick();
    send_key(128'hfedcba9876543210fedcba9876543210);
    tick();
    tx_busy = 1'b1;
    send_pt(128'h66666666666666666666666666666666);
    core_finish(128'h88888888888888888888888888888888, 3);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst in SEND");
    exp_tx_q.delete();
    exp_blk = '0;
    n_key_load = 0;
    n_start = 0;
    tx_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_key(128'h0badc0de0badc0de0badc0de0badc0de);
    tick();
    send_pt(128'h12121212343434345656565678787878);
    core_finish(128'habababababababababababababababab, 2);
    wait_idle("t6");
    tick();
    chk("blk_cnt after reset", 128'(blk_cnt), 128'(1));
    chk("key loads after reset", 128'(n_key_load), 128'(1));
    chk("starts after reset", 128'(n_start), 128'(1));
    chk("key queue drained", 128'(exp_key_q.size()), 128'(0));
    chk("din queue drained", 128'(exp_din_q.size()), 128'(0));
    chk("tx queue drained", 128'(exp_tx_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
